// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Resolves branch / jal / jalr targets and keeps a direct-mapped branch
//   target buffer (BTB) with 2-bit saturating counters. Fetch looks up a PC
//   and receives a registered next-PC prediction one cycle later. Execute
//   resolves control-flow instructions; a mispredict is flagged one cycle
//   later together with the correct next PC.
//
// Ports
//   CLK, RST_N                 clock, synchronous active-low reset
//   fetch_valid, fetch_pc      lookup request
//   flush                      kills the in-flight lookup result (pred_valid only)
//   pred_valid/taken/target    registered prediction for the previous lookup
//   res_valid, res_type        resolve request; type 00 br, 01 jal, 10 jalr, 11 ignored
//   res_pc, res_imm, res_rs1   operands for target arithmetic
//   res_taken                  actual branch outcome (branch only)
//   res_pred_taken/target      prediction carried down the pipe
//   mispredict, redirect_pc    registered resolve result
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            flush,
    input  logic            res_valid,
    input  logic [1:0]      res_type,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_imm,
    input  logic [XLEN-1:0] res_rs1,
    input  logic            res_taken,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    localparam logic [1:0] TYPE_BRANCH = 2'b00;
    localparam logic [1:0] TYPE_JALR   = 2'b10;
    localparam logic [1:0] TYPE_RSVD   = 2'b11;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    // Saturating counter helpers
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // BTB storage
    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [1:0]          type_r   [ENTRIES];
    logic [XLEN-1:0]     target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx_s;
    logic                lk_hit_s;
    logic                lk_taken_s;
    logic [XLEN-1:0]     lk_target_s;

    logic [IDX_BITS-1:0] rs_idx_s;
    logic                rs_hit_s;
    logic                rs_active_s;
    logic                rs_taken_s;
    logic [XLEN-1:0]     rs_sum_s;
    logic [XLEN-1:0]     rs_target_s;
    logic [XLEN-1:0]     rs_next_s;
    logic                rs_misp_s;
    logic [1:0]          rs_ctr_next_s;
    logic                rs_wr_ent_s;
    logic                rs_wr_ctr_s;

    // Lookup: read current (pre-update) BTB contents
    always_comb begin
        lk_idx_s = fetch_pc[IDX_BITS+1:2];
        lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == fetch_pc[XLEN-1:IDX_BITS+2]);
        // Non-branch entries are unconditionally taken; branches follow counter MSB
        if (fetch_valid && lk_hit_s &&
            ((type_r[lk_idx_s] != TYPE_BRANCH) || ctr_r[lk_idx_s][1])) begin
            lk_taken_s = 1'b1;
        end else begin
            lk_taken_s = 1'b0;
        end
        lk_target_s = lk_taken_s ? target_r[lk_idx_s] : fetch_pc + PC_STEP;
    end

    // Resolve: target arithmetic, mispredict detection and BTB update decision
    always_comb begin
        rs_idx_s    = res_pc[IDX_BITS+1:2];
        rs_hit_s    = valid_r[rs_idx_s] && (tag_r[rs_idx_s] == res_pc[XLEN-1:IDX_BITS+2]);
        rs_active_s = res_valid && (res_type != TYPE_RSVD);
        rs_sum_s    = res_rs1 + res_imm;
        case (res_type)
            TYPE_BRANCH: begin
                rs_target_s = res_pc + res_imm;
                rs_taken_s  = res_taken;
            end
            TYPE_JALR: begin
                rs_target_s = {rs_sum_s[XLEN-1:1], 1'b0};
                rs_taken_s  = 1'b1;
            end
            default: begin
                rs_target_s = res_pc + res_imm;
                rs_taken_s  = 1'b1;
            end
        endcase
        rs_next_s = rs_taken_s ? rs_target_s : res_pc + PC_STEP;
        rs_misp_s = rs_active_s &&
                    ((rs_taken_s != res_pred_taken) ||
                     (rs_taken_s && (res_pred_target != rs_target_s)));

        if (rs_hit_s) begin
            if (!rs_taken_s) begin
                rs_ctr_next_s = ctr_dec(ctr_r[rs_idx_s]);
            end else if (res_type != TYPE_BRANCH) begin
                rs_ctr_next_s = 2'b11;
            end else begin
                rs_ctr_next_s = ctr_inc(ctr_r[rs_idx_s]);
            end
        end else if (res_type == TYPE_BRANCH) begin
            rs_ctr_next_s = 2'b10;
        end else begin
            rs_ctr_next_s = 2'b11;
        end
        // Taken resolves (re)write the entry; not-taken only touches a hit counter
        rs_wr_ent_s = rs_active_s && rs_taken_s;
        rs_wr_ctr_s = rs_active_s && (rs_hit_s || rs_taken_s);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                type_r[i]   <= 2'b00;
                target_r[i] <= '0;
                ctr_r[i]    <= 2'b01;
            end
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            pred_valid  <= fetch_valid && !flush;
            pred_taken  <= lk_taken_s;
            pred_target <= lk_target_s;
            mispredict  <= rs_misp_s;
            redirect_pc <= rs_next_s;
            if (rs_wr_ent_s) begin
                valid_r[rs_idx_s]  <= 1'b1;
                tag_r[rs_idx_s]    <= res_pc[XLEN-1:IDX_BITS+2];
                type_r[rs_idx_s]   <= res_type;
                target_r[rs_idx_s] <= rs_target_s;
            end
            if (rs_wr_ctr_s) begin
                ctr_r[rs_idx_s] <= rs_ctr_next_s;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (XLEN=32, ENTRIES=16):
// directed scenarios followed by randomized traffic against a reference model.
module tb_branch_target_predictor;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic        res_valid;
    logic [1:0]  res_type;
    logic [31:0] res_pc;
    logic [31:0] res_imm;
    logic [31:0] res_rs1;
    logic        res_taken;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one record per BTB slot, counter held as an integer 0..3
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [1:0]  m_type  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    branch_target_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .flush(flush),
        .res_valid(res_valid), .res_type(res_type), .res_pc(res_pc),
        .res_imm(res_imm), .res_rs1(res_rs1), .res_taken(res_taken),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    function automatic logic [31:0] calc_tgt(input logic [1:0] rt, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [31:0] rs1);
        if (rt == 2'b10) return (rs1 + imm) & ~32'h1;
        return pc + imm;
    endfunction

    // One clock: drive inputs, predict outputs from the model, advance, compare
    task automatic step(input bit fv, input logic [31:0] fpc, input bit fl,
                        input bit rv, input logic [1:0] rt, input logic [31:0] rpc,
                        input logic [31:0] rimm, input logic [31:0] rrs1, input bit rtk,
                        input bit rpt, input logic [31:0] rptgt);
        int li, ri;
        bit hit, act, at, e_pt, e_mp;
        logic [31:0] e_ptgt, e_rd, tgt;
        fetch_valid = fv; fetch_pc = fpc; flush = fl;
        res_valid = rv; res_type = rt; res_pc = rpc; res_imm = rimm; res_rs1 = rrs1;
        res_taken = rtk; res_pred_taken = rpt; res_pred_target = rptgt;

        li     = int'((fpc / 32'd4) % 32'd16);
        hit    = m_valid[li] && (m_tag[li] == fpc / 32'd64);
        e_pt   = fv && hit && (m_type[li] != 2'b00 || m_ctr[li] >= 2);
        e_ptgt = e_pt ? m_tgt[li] : fpc + 32'd4;

        act  = rv && (rt != 2'b11);
        e_mp = 1'b0;
        e_rd = 32'h0;
        if (act) begin
            tgt  = calc_tgt(rt, rpc, rimm, rrs1);
            at   = (rt == 2'b00) ? rtk : 1'b1;
            e_mp = (at != rpt) || (at && rptgt != tgt);
            e_rd = at ? tgt : rpc + 32'd4;
            ri   = int'((rpc / 32'd4) % 32'd16);
            if (m_valid[ri] && m_tag[ri] == rpc / 32'd64) begin
                if (at) begin
                    m_ctr[ri]  = (rt != 2'b00) ? 3 : ((m_ctr[ri] + 1 > 3) ? 3 : m_ctr[ri] + 1);
                    m_type[ri] = rt;
                    m_tgt[ri]  = tgt;
                end else begin
                    m_ctr[ri] = (m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1;
                end
            end else if (at) begin
                m_valid[ri] = 1'b1;
                m_tag[ri]   = rpc / 32'd64;
                m_type[ri]  = rt;
                m_tgt[ri]   = tgt;
                m_ctr[ri]   = (rt == 2'b00) ? 2 : 3;
            end
        end

        @(posedge CLK);
        #1;
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, fv && !fl});
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
        if (fv) chk("pred_target", pred_target, e_ptgt);
        chk("mispredict", {31'd0, mispredict}, {31'd0, e_mp});
        if (act) chk("redirect_pc", redirect_pc, e_rd);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [1:0] rt, input logic [31:0] rpc, input logic [31:0] rimm,
                           input logic [31:0] rrs1, input bit rtk, input bit rpt,
                           input logic [31:0] rptgt);
        step(1'b0, 32'h0, 1'b0, 1'b1, rt, rpc, rimm, rrs1, rtk, rpt, rptgt);
    endtask

    // Reset with arbitrary traffic on the inputs; everything must return to zero
    task automatic do_reset();
        RST_N = 1'b0;
        fetch_valid = 1'b1; fetch_pc = $urandom(); flush = 1'b0;
        res_valid = 1'b1; res_type = 2'b01; res_pc = $urandom(); res_imm = $urandom();
        res_rs1 = $urandom(); res_taken = 1'b1; res_pred_taken = 1'b0; res_pred_target = $urandom();
        @(posedge CLK);
        #1;
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        model_reset();
        RST_N = 1'b1;
    endtask

    initial begin
        logic [31:0] fpc, rpc, rimm, rrs1, rptgt;
        logic [1:0]  rt;
        model_reset();
        RST_N = 1'b0;
        fetch_valid = 1'b0; fetch_pc = 32'h0; flush = 1'b0;
        res_valid = 1'b0; res_type = 2'b00; res_pc = 32'h0; res_imm = 32'h0;
        res_rs1 = 32'h0; res_taken = 1'b0; res_pred_taken = 1'b0; res_pred_target = 32'h0;
        @(posedge CLK);
        do_reset();

        // Cold lookup misses
        lookup(32'h100);
        chk("cold_target", pred_target, 32'h104);

        // Taken branch allocates with weakly-taken counter
        resolve(2'b00, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("br_misp", {31'd0, mispredict}, 32'd1);
        chk("br_redirect", redirect_pc, 32'h120);
        lookup(32'h100);
        chk("br_hit_taken", {31'd0, pred_taken}, 32'd1);
        chk("br_hit_target", pred_target, 32'h120);

        // Not-taken twice: 10 -> 01 -> 00, then a third saturates at 00
        resolve(2'b00, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 32'h120);
        resolve(2'b00, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        lookup(32'h100);
        chk("nt_target", pred_target, 32'h104);
        resolve(2'b00, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(2'b00, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
        lookup(32'h100);
        chk("sat_floor_taken", {31'd0, pred_taken}, 32'd0);

        // jalr target clears bit 0
        resolve(2'b10, 32'h208, 32'h4, 32'h2001, 1'b0, 1'b1, 32'h2004);
        chk("jalr_ok_misp", {31'd0, mispredict}, 32'd0);
        chk("jalr_redirect", redirect_pc, 32'h2004);
        resolve(2'b10, 32'h208, 32'h4, 32'h2001, 1'b0, 1'b0, 32'h2004);
        chk("jalr_bad_misp", {31'd0, mispredict}, 32'd1);

        // Alias: jal at 0x140 evicts 0x100 (same index)
        resolve(2'b01, 32'h140, 32'h40, 32'h0, 1'b0, 1'b1, 32'h180);
        lookup(32'h100);
        chk("alias_miss", pred_target, 32'h104);
        lookup(32'h140);
        chk("alias_hit", pred_target, 32'h180);

        // Same-cycle lookup and resolve: old contents first, new next cycle
        step(1'b1, 32'h140, 1'b0, 1'b1, 2'b01, 32'h140, 32'h80, 32'h0, 1'b0, 1'b1, 32'h180);
        chk("rbw_old", pred_target, 32'h180);
        step(1'b1, 32'h140, 1'b1, 1'b1, 2'b01, 32'h140, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1c0);
        chk("flush_old", pred_target, 32'h1c0);
        lookup(32'h140);
        chk("flush_update_landed", pred_target, 32'h240);

        // Wrap-around target
        resolve(2'b00, 32'hffff_fffc, 32'h8, 32'h0, 1'b1, 1'b1, 32'h4);
        chk("wrap_redirect", redirect_pc, 32'h4);

        // Reserved type ignored
        resolve(2'b11, 32'h140, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
        lookup(32'h140);

        do_reset();
        lookup(32'h140);

        // Randomized traffic over a small PC pool to get hits and aliases
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                fpc  = 32'h100 + ($urandom_range(0, 7) * 32'd4) + ($urandom_range(0, 2) * 32'd64);
                rpc  = 32'h100 + ($urandom_range(0, 7) * 32'd4) + ($urandom_range(0, 2) * 32'd64);
                if ($urandom_range(0, 9) == 0) fpc = $urandom();
                rt   = 2'($urandom_range(0, 3));
                rimm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) * 32'd4 : $urandom();
                rrs1 = $urandom();
                rptgt = ($urandom_range(0, 1) == 1) ? calc_tgt(rt, rpc, rimm, rrs1) : $urandom();
                step(1'($urandom_range(0, 1)), fpc, ($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 1)), rt, rpc, rimm, rrs1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rptgt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised successor to the combinational branch/jal/jalr target adder. It computes resolved targets for branch, jal and jalr internally. It also keeps a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, giving fetch a registered next-PC prediction one cycle after lookup. It sits between fetch (lookup port) and execute (resolve port), and flags mispredicts with a redirect PC.

Parameters:
XLEN, 32, datapath width for PC, immediates, rs1 and targets.
ENTRIES, 16, BTB entry count; power of two, minimum 2; IDX_BITS = log2(ENTRIES).
TAG_BITS, XLEN-IDX_BITS-2, derived tag width; not overridden.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  synchronous active-low reset
fetch_valid  in  1  lookup request this cycle
fetch_pc  in  XLEN  PC to look up
pred_valid  out  1  registered: prediction for the previous-cycle lookup is valid
pred_taken  out  1  registered predicted-taken
pred_target  out  XLEN  registered predicted next PC
flush  in  1  kills the in-flight lookup result
res_valid  in  1  resolved control-flow instruction this cycle
res_type  in  2  00 branch, 01 jal, 10 jalr, 11 reserved (ignored)
res_pc  in  XLEN  PC of the resolved instruction
res_imm  in  XLEN  sign-extended B/J/I immediate matching res_type
res_rs1  in  XLEN  rs1 value (jalr only)
res_taken  in  1  actual branch outcome; ignored for jal/jalr (always taken)
res_pred_taken  in  1  prediction that was carried down the pipe with the instruction
res_pred_target  in  XLEN  predicted target that was carried down the pipe
mispredict  out  1  registered: previous-cycle resolve was mispredicted
redirect_pc  out  XLEN  registered: correct next PC for that resolve

Behaviour:
- Reset (RST_N=0 at a rising edge): all entry valid bits 0; counters 2'b01; pred_valid, pred_taken, mispredict 0; pred_target, redirect_pc 0. Reset overrides every other input.
- Index is PC[IDX_BITS+1:2]. Tag is PC[XLEN-1:IDX_BITS+2].
- Entry contents: valid, tag, type, target, 2-bit counter.
- Target arithmetic, modulo 2^XLEN, wraps silently:
  - branch and jal: res_pc + res_imm.
  - jalr: (res_rs1 + res_imm) with bit 0 cleared.
  - fallthrough: res_pc + 4.
- Lookup, latency 1:
  - pred_valid <= fetch_valid & ~flush.
  - hit = entry valid and tag equal.
  - pred_taken <= hit & (type != branch | counter[1]).
  - pred_target <= pred_taken ? stored target : fetch_pc + 4.
  - When fetch_valid=0, pred_valid=0 and pred_taken=0; pred_target is don't-care.
- Resolve, on res_valid with res_type != 11:
  - actual_taken = res_taken for branch, 1 otherwise.
  - actual_next = actual_taken ? computed target : fallthrough.
  - mispredict <= (actual_taken != res_pred_taken) | (actual_taken & res_pred_target != computed target).
  - redirect_pc <= actual_next, latency 1.
  - When res_valid=0 or type is 11: mispredict <= 0 and BTB unchanged.
- BTB update on resolve:
  - Hit: counter saturating increment when taken, decrement when not taken (11 and 00 saturate). Overwrite target and type when taken. jal/jalr force counter 11.
  - Miss and taken: allocate (overwrite any occupant), valid=1, new tag/type/target. Counter 10 for branch, 11 for jal/jalr.
  - Miss and not taken: no allocation.
- Simultaneous lookup and resolve on the same index: the lookup returns the pre-update contents (read-before-write). The update is visible from the next cycle.
- flush affects only pred_valid. It does not block a resolve in the same cycle.
- Reset mid-operation: results in flight are discarded; outputs return to their reset values the next cycle.

Test Plan:
- Reset then lookup fetch_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Resolve branch res_pc=0x100, res_imm=0x20, taken, res_pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x120. A later lookup of 0x100 gives pred_taken=1, pred_target=0x120.
- Same branch resolved not-taken twice -> counter 10 to 01 to 00; lookup of 0x100 gives pred_taken=0, pred_target=0x104. A third not-taken saturates at 00.
- jalr res_rs1=0x2001, res_imm=0x4, res_pred_target=0x2004 -> target 0x2004; mispredict=0 when res_pred_taken=1, mispredict=1 when res_pred_taken=0.
- Alias with ENTRIES=16: allocate 0x100, then taken jal at 0x140 (same index) -> lookup 0x100 misses (pred_target=0x104); lookup 0x140 hits.
- Lookup and resolve of the same PC in one cycle -> lookup returns old contents; flush in the same cycle gives pred_valid=0 while the update still lands. Wrap case: res_pc=0xFFFFFFFC, res_imm=8 -> target 0x00000004.
